// File: rtl/vga_capture.sv
// VGA capture: locks onto a fixed active-video geometry and writes a 2x-decimated
// RGB332 image of each valid frame into a byte-addressed framebuffer.
module vga_capture #(
  parameter int ADDR_WIDTH  = 18,
  parameter int WIDTH_SHIFT = 9,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  input  logic [8:0]            color_in,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic                  write_enable,
  output logic                  locked,
  output logic                  frame_done,
  output logic                  sync_err
);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [10:0] H_CNT = 11'(H_ACTIVE);
  localparam logic [10:0] V_CNT = 11'(V_ACTIVE);
  localparam int          SUM_W = (ADDR_WIDTH > WIDTH_SHIFT + 11) ? ADDR_WIDTH : WIDTH_SHIFT + 11;

  state_t      state;
  logic        hs_r, vs_r, de_r;
  logic [8:0]  color_r;
  logic        vs_d, de_d;
  logic [10:0] px, ln;
  logic        bad_frame;

  logic             de_fall, frame_start, hs_err;
  logic             px_ok, ln_ok, line_bad, wr_hit;
  logic [SUM_W-1:0] addr_full;

  // Input stage plus the one-cycle-delayed copies used for edge detection.
  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // so vs_d/de_d genuinely lag vs_r/de_r by exactly one cycle.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      hs_r    <= 1'b0;
      vs_r    <= 1'b0;
      de_r    <= 1'b0;
      color_r <= '0;
      vs_d    <= 1'b0;
      de_d    <= 1'b0;
    end else begin
      hs_r    <= hsync;
      vs_r    <= vsync;
      de_r    <= de;
      color_r <= color_in;
      vs_d    <= vs_r;
      de_d    <= de_r;
    end
  end

  assign de_fall     = de_d & ~de_r;
  assign frame_start = vs_d & ~vs_r;
  assign hs_err      = de_r & ~hs_r;
  assign px_ok       = (px == H_CNT);
  assign ln_ok       = (ln == V_CNT);
  assign line_bad    = de_fall & ~px_ok;

  // Counters saturate so a stuck de can never wrap back into the active window.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      px <= '0;
      ln <= '0;
    end else begin
      if (de_fall)
        px <= '0;
      else if (de_r && px != '1)
        px <= px + 11'd1;

      if (frame_start)
        ln <= '0;
      else if (de_fall && ln != '1)
        ln <= ln + 11'd1;
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state      <= WAIT_SYNC;
      bad_frame  <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (hs_err) begin
        sync_err <= 1'b1;
        state    <= WAIT_SYNC;
      end else begin
        unique case (state)
          WAIT_SYNC: begin
            if (frame_start) begin
              state     <= MEASURE;
              bad_frame <= 1'b0;
            end
          end
          MEASURE: begin
            // A bad line is remembered and only reported when the frame closes.
            if (line_bad)
              bad_frame <= 1'b1;
            if (frame_start) begin
              bad_frame <= 1'b0;
              if (!(bad_frame || line_bad) && ln_ok)
                state <= LOCKED;
              else
                sync_err <= 1'b1;
            end
          end
          LOCKED: begin
            if (line_bad || (frame_start && !ln_ok)) begin
              sync_err <= 1'b1;
              state    <= WAIT_SYNC;
            end else if (frame_start) begin
              frame_done <= 1'b1;
            end
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

  assign locked = (state == LOCKED);

  // Keep every other pixel of every other line, inside the active window only.
  assign wr_hit = (state == LOCKED) & de_r & ~hs_err & ~px[0] & ~ln[0]
                & (px < H_CNT) & (ln < V_CNT);

  assign addr_full = (SUM_W'(ln[10:1]) << WIDTH_SHIFT) + SUM_W'(px[10:1]);

  always_ff @(posedge clk50M) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= wr_hit;
      if (wr_hit) begin
        write_addr <= addr_full[ADDR_WIDTH-1:0];
        write_data <= {color_r[2:0], color_r[5:3], color_r[8:7]};
      end
    end
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter ADDR_WIDTH, default 18, framebuffer write address width.
REQ-002 Parameter WIDTH_SHIFT, default 9, log2 of framebuffer row pitch in pixels.
REQ-003 Parameter H_ACTIVE, default 800, required de-high pixels per line.
REQ-004 Parameter V_ACTIVE, default 600, required de-high lines per frame.
REQ-005 clk50M  input  1  pixel clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 hsync  input  1  horizontal sync, low during the sync pulse.
REQ-008 vsync  input  1  vertical sync, low during the sync pulse.
REQ-009 de  input  1  data enable, high for visible pixels.
REQ-010 color_in  input  9  pixel colour {blue[2:0], green[2:0], red[2:0]}.
REQ-011 write_addr  output  ADDR_WIDTH  framebuffer byte address.
REQ-012 write_data  output  8  framebuffer pixel {red[2:0], green[2:0], blue[2:1]}.
REQ-013 write_enable  output  1  one-cycle write strobe; addr/data valid only while high.
REQ-014 locked  output  1  high while the capture FSM is in LOCKED.
REQ-015 frame_done  output  1  one-cycle pulse at the end of each fully written frame.
REQ-016 sync_err  output  1  one-cycle pulse on a timing mismatch.

Function
REQ-017 hsync, vsync, de and color_in SHALL be registered once (input stage) before any other use; edge detection uses the registered value against its one-cycle-delayed copy.
REQ-018 Pixel counter px (11 bits) SHALL increment on each registered de-high cycle and clear on the registered de falling edge.
REQ-019 Line counter ln (11 bits) SHALL increment on each registered de falling edge and clear on the registered vsync falling edge.
REQ-020 Frame start SHALL be the registered vsync falling edge.
REQ-021 FSM states: WAIT_SYNC, MEASURE, LOCKED.
REQ-022 WAIT_SYNC -> MEASURE on frame start.
REQ-023 MEASURE -> LOCKED on the next frame start if every line of the measured frame had px == H_ACTIVE at de fall and ln == V_ACTIVE at that frame start; otherwise MEASURE -> MEASURE with sync_err pulsed.
REQ-024 In LOCKED, any de fall with px != H_ACTIVE, or any frame start with ln != V_ACTIVE, SHALL pulse sync_err and enter WAIT_SYNC; the partially written frame produces no frame_done.
REQ-025 In LOCKED, a frame start with ln == V_ACTIVE SHALL pulse frame_done in the same cycle as the transition and remain in LOCKED.
REQ-026 A de-high cycle with more than H_ACTIVE pixels, or more than V_ACTIVE lines, SHALL be detected at the following de fall or frame start, with no write issued for px >= H_ACTIVE or ln >= V_ACTIVE.
REQ-027 Writes SHALL occur only in LOCKED, and only for registered de-high cycles where px[0] == 0 and ln[0] == 0 (2x decimation, 400x300 at the defaults).
REQ-028 write_addr = {ln[10:1], WIDTH_SHIFT zero bits} + px[10:1], truncated to ADDR_WIDTH.
REQ-029 write_data = {red, green, blue[2:1]} of the decimated pixel.
REQ-030 Latency: write_enable SHALL be high exactly 2 cycles after the port cycle that carried the pixel (input register plus output register).
REQ-031 At most one write per cycle; write_enable SHALL never be high for two consecutive cycles.
REQ-032 An hsync edge SHALL be ignored for counting; hsync is monitored only so that a de-high cycle during a registered hsync-low cycle is a sync_err in any state.

Reset
REQ-033 While rst is high: FSM = WAIT_SYNC; px = ln = 0; write_enable, locked, frame_done and sync_err = 0; write_addr and write_data = 0; input and edge registers = 0 (idle).
REQ-034 Reset asserted mid-frame SHALL take effect at the next edge; no write occurs in the following cycle.
REQ-035 After rst deasserts, no write occurs until two full valid frames have been seen (WAIT_SYNC -> MEASURE -> LOCKED).

Verification
REQ-036 Reset, then three ideal 800x600 frames (1040x666 timing) -> locked rises at the second frame start; third frame gives 120000 writes and one frame_done.
REQ-037 Locked, pixel (x=2,y=4) colour 9'b111_010_101 -> write_addr 0x401 (2<<9 + 1), write_data 8'b101_010_11, write_enable 2 cycles after that pixel.
REQ-038 Locked, one line with 799 de cycles -> sync_err pulse at that de fall, locked = 0, no frame_done, no further writes until relocked.
REQ-039 Frame of 601 active lines during MEASURE -> no write for line 600, sync_err at frame start, FSM stays MEASURE, locked stays 0.
REQ-040 rst pulsed mid-line while locked -> outputs zero next cycle, no write during reset, relock only after two good frames.
REQ-041 de high while hsync low -> sync_err pulse, FSM = WAIT_SYNC.
